// File: rtl/uart_cmd_decoder.sv
// Byte-stream command decoder: frames of A5/ADDR/DATA/CSUM write one of four
// 8-bit registers; malformed frames and stalled partial frames are reported.
module uart_cmd_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 12_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        received,
    output logic [31:0] regs,
    output logic        wr_strobe,
    output logic [1:0]  wr_addr,
    output logic        frame_err,
    output logic        timeout,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_CSUM = 2'd3
    } state_t;

    localparam logic [7:0]  SYNC_BYTE = 8'hA5;
    localparam logic [7:0]  CSUM_KEY  = 8'h5A;
    // The counter expires on the edge where it would step onto TIMEOUT_CYCLES-1.
    localparam logic [23:0] EXPIRE_AT = 24'(TIMEOUT_CYCLES - 32'd2);

    function automatic logic [7:0] frame_csum(input logic [7:0] addr, input logic [7:0] data);
        return addr ^ data ^ CSUM_KEY;
    endfunction

    state_t      state_q, state_d;
    logic [23:0] cnt_q, cnt_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic [31:0] regs_q, regs_d;
    logic        wr_strobe_q, wr_strobe_d;
    logic [1:0]  wr_addr_q, wr_addr_d;
    logic        frame_err_q, frame_err_d;
    logic        timeout_q, timeout_d;
    logic        busy_q, busy_d;

    // Next-state: a received byte always takes precedence over timeout expiry.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        data_d      = data_q;
        regs_d      = regs_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        frame_err_d = 1'b0;
        timeout_d   = 1'b0;
        if (received) begin
            cnt_d = 24'd0;
            case (state_q)
                ST_IDLE: begin
                    if (rx_data == SYNC_BYTE) begin
                        state_d = ST_ADDR;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_ADDR: begin
                    addr_d  = rx_data;
                    state_d = ST_DATA;
                end
                ST_DATA: begin
                    data_d  = rx_data;
                    state_d = ST_CSUM;
                end
                ST_CSUM: begin
                    state_d = ST_IDLE;
                    if ((rx_data == frame_csum(addr_q, data_q)) && (addr_q[7:2] == 6'd0)) begin
                        regs_d[{addr_q[1:0], 3'b000} +: 8] = data_q;
                        wr_strobe_d = 1'b1;
                        wr_addr_d   = addr_q[1:0];
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else if (state_q == ST_IDLE) begin
            cnt_d = 24'd0;
        end else if (cnt_q == EXPIRE_AT) begin
            state_d   = ST_IDLE;
            cnt_d     = 24'd0;
            timeout_d = 1'b1;
        end else begin
            cnt_d = cnt_q + 24'd1;
        end
        busy_d = (state_d != ST_IDLE);
    end

    // State, register file and all outputs are registered together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 24'd0;
            addr_q      <= 8'd0;
            data_q      <= 8'd0;
            regs_q      <= 32'd0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= 2'd0;
            frame_err_q <= 1'b0;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            regs_q      <= regs_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            frame_err_q <= frame_err_d;
            timeout_q   <= timeout_d;
            busy_q      <= busy_d;
        end
    end

    assign regs      = regs_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign frame_err = frame_err_q;
    assign timeout   = timeout_q;
    assign busy      = busy_q;

endmodule
